// File: rtl/muxn_rr.sv
// muxn_rr: N-channel W-bit registered mux with explicit-select or round-robin
// arbitration and valid/ready handshakes on every channel.
// Ports:
//   clk, reset      rising-edge clock, synchronous active-high reset
//   mode, sel       0 = take channel sel, 1 = round-robin from internal pointer
//   in_data/valid   N packed channels (channel k at [k*W +: W]) and their valids
//   in_ready        one-hot (or zero) accept back to the granted channel
//   out_data/chan   registered item and the channel index it came from
//   out_valid/ready output handshake; one item per cycle when out_ready stays high
module muxn_rr #(
    parameter  int N  = 4,
    parameter  int W  = 16,
    localparam int SW = $clog2(N)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           mode,
    input  logic [SW-1:0]  sel,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_valid,
    output logic [N-1:0]   in_ready,
    output logic [W-1:0]   out_data,
    output logic [SW-1:0]  out_chan,
    output logic           out_valid,
    input  logic           out_ready
);
    logic [W-1:0]  r_data;
    logic [SW-1:0] r_chan;
    logic          r_valid;
    logic [SW-1:0] r_ptr;
    logic [SW-1:0] w_gnt;
    logic [SW-1:0] w_idx;
    logic          w_gnt_vld;
    logic          w_gnt_ok;
    logic          w_load;
    logic          w_xfer;

    assign w_load = !r_valid || out_ready;

    // Round-robin scans from the highest offset down so the channel closest
    // to the pointer is the last (winning) assignment.
    always_comb begin
        w_gnt     = sel;
        w_gnt_vld = int'(sel) < N;
        w_idx     = '0;
        if (mode) begin
            w_gnt     = '0;
            w_gnt_vld = 1'b0;
            for (int i = N - 1; i >= 0; i--) begin
                w_idx = SW'((int'(r_ptr) + i) % N);
                if (in_valid[w_idx]) begin
                    w_gnt     = w_idx;
                    w_gnt_vld = 1'b1;
                end
            end
        end
    end

    assign w_gnt_ok = !reset && w_gnt_vld;
    assign in_ready = w_gnt_ok ? (N'(w_load) << w_gnt) : '0;
    assign w_xfer   = w_gnt_ok && w_load && in_valid[w_gnt];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data  <= '0;
            r_chan  <= '0;
            r_valid <= 1'b0;
            r_ptr   <= '0;
        end else if (w_xfer) begin
            r_data  <= in_data[int'(w_gnt)*W +: W];
            r_chan  <= w_gnt;
            r_valid <= 1'b1;
            if (mode)
                r_ptr <= SW'((int'(w_gnt) + 1) % N);
        end else if (out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign out_data  = r_data;
    assign out_chan  = r_chan;
    assign out_valid = r_valid;
endmodule

// File: tb/tb_muxn_rr.sv
// tb_muxn_rr: directed and randomized checks of muxn_rr against a behavioural model.
module tb_muxn_rr;
    localparam int N  = 4;
    localparam int W  = 16;
    localparam int SW = 2;

    logic           clk = 1'b0;
    logic           reset;
    logic           mode;
    logic [SW-1:0]  sel;
    logic [N*W-1:0] in_data;
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [W-1:0]   out_data;
    logic [SW-1:0]  out_chan;
    logic           out_valid;
    logic           out_ready;

    int n_chk  = 0;
    int n_fail = 0;

    logic         m_valid = 1'b0;
    logic [W-1:0] m_data  = '0;
    int           m_chan  = 0;
    int           m_ptr   = 0;

    always #5 clk = ~clk;

    muxn_rr #(.N(N), .W(W)) dut (
        .clk(clk), .reset(reset), .mode(mode), .sel(sel),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_chan(out_chan), .out_valid(out_valid),
        .out_ready(out_ready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] chan_data(input int k);
        return in_data[k*W +: W];
    endfunction

    // Granted channel by the rules, or -1 when nothing is granted.
    function automatic int grant();
        if (reset) return -1;
        if (!mode) return (int'(sel) < N) ? int'(sel) : -1;
        for (int i = 0; i < N; i++)
            if (in_valid[(m_ptr + i) % N]) return (m_ptr + i) % N;
        return -1;
    endfunction

    task automatic set_data(input logic [W-1:0] d0, d1, d2, d3);
        in_data = {d3, d2, d1, d0};
    endtask

    task automatic cyc();
        int   g;
        logic ld;
        logic [31:0] er;
        #1;
        g  = grant();
        ld = !m_valid || out_ready;
        er = (g >= 0 && ld) ? (32'd1 << g) : 32'd0;
        check("in_ready", {28'd0, in_ready}, er);
        @(posedge clk);
        #1;
        if (reset) begin
            m_valid = 1'b0; m_data = '0; m_chan = 0; m_ptr = 0;
        end else if (g >= 0 && ld && in_valid[g]) begin
            m_valid = 1'b1; m_data = chan_data(g); m_chan = g;
            if (mode) m_ptr = (g + 1) % N;
        end else if (out_ready) begin
            m_valid = 1'b0;
        end
        check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        check("out_data", {16'd0, out_data}, {16'd0, m_data});
        check("out_chan", {30'd0, out_chan}, m_chan);
    endtask

    initial begin
        logic [W-1:0] held_d;
        logic [SW-1:0] held_c;
        reset = 1'b1; mode = 1'b1; sel = '0; in_valid = '1; out_ready = 1'b1;
        set_data(16'h1111, 16'h2222, 16'h3333, 16'h4444);
        repeat (2) cyc();
        check("rst_data", {16'd0, out_data}, 32'h0);
        reset = 1'b0;
        cyc();
        check("first_rr", {30'd0, out_chan}, 32'd0);
        check("first_rr_data", {16'd0, out_data}, 32'h1111);

        mode = 1'b0;
        set_data(16'h0000, 16'hFFFF, 16'h0001, 16'h1234);
        sel = 2'd2; cyc();
        check("sel2", {16'd0, out_data}, 32'h0001);
        sel = 2'd3; cyc();
        check("sel3", {16'd0, out_data}, 32'h1234);
        for (int s = 0; s < N; s++) begin
            sel = SW'(s); cyc();
            check("sweep_chan", {30'd0, out_chan}, s);
            check("sweep_data", {16'd0, out_data}, {16'd0, chan_data(s)});
        end

        reset = 1'b1; cyc(); reset = 1'b0;
        mode = 1'b1;
        for (int i = 0; i < 8; i++) begin
            cyc();
            check("fair_chan", {30'd0, out_chan}, i % N);
            check("fair_valid", {31'd0, out_valid}, 32'd1);
        end

        in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            cyc();
            check("sparse", {30'd0, out_chan}, (i % 2) ? 32'd3 : 32'd1);
        end
        cyc();
        check("sparse_1", {30'd0, out_chan}, 32'd1);
        in_valid = 4'b0010;
        cyc();
        check("sparse_wrap", {30'd0, out_chan}, 32'd1);

        in_valid = '1; out_ready = 1'b0;
        held_d = out_data; held_c = out_chan;
        repeat (3) begin
            cyc();
            check("bp_data", {16'd0, out_data}, {16'd0, held_d});
            check("bp_chan", {30'd0, out_chan}, {30'd0, held_c});
        end
        out_ready = 1'b1;
        cyc();
        check("bp_release", {30'd0, out_chan}, (int'(held_c) + 1) % N);

        out_ready = 1'b0;
        reset = 1'b1; cyc();
        check("midrst_valid", {31'd0, out_valid}, 32'd0);
        reset = 1'b0; in_valid = '0;
        repeat (2) cyc();
        check("midrst_idle", {31'd0, out_valid}, 32'd0);
        in_valid = '1; mode = 1'b1; out_ready = 1'b1;
        cyc();
        check("midrst_ptr", {30'd0, out_chan}, 32'd0);

        for (int i = 0; i < 3000; i++) begin
            reset     = ($urandom_range(0, 49) == 0);
            mode      = ($urandom_range(0, 3) != 0);
            sel       = SW'($urandom_range(0, N - 1));
            in_valid  = N'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            in_data   = {$urandom, $urandom};
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
